tdc_event_stamper: RTL and testbench
====================================

# tdc_event_stamper

Parametrised successor to the single-line TDC sampler. It takes the per-cycle sampled tap vector of a carry-chain delay line and detects rising and/or falling edges of the measured signal. For each edge it converts the thermometer code into a bubble-tolerant fine count and combines it with a free-running coarse counter. The resulting event records are buffered in an internal FIFO and presented on a valid/ready stream that feeds the UART streamer or a later histogram block.

## Interface
- TAPS, 241: width of the sampled tap vector (delay-line length).
- COARSE_W, 16: coarse cycle counter width; wraps modulo 2^COARSE_W.
- DEPTH, 16: FIFO entries; power of 2, ≥2.
- EDGE_MODE, 0: 0 = rising only, 1 = falling only, 2 = both.
- Derived: FINE_W = $clog2(TAPS+1); REC_W = 2 + COARSE_W + FINE_W.

Ports:
- clk  in  1  sampling clock, same clock as the delay-line flops.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  event detection enable; coarse counter runs regardless.
- taps  in  TAPS  sampled delay line; taps[0] is nearest the input.
- m_valid  out  1  record available.
- m_ready  in  1  consumer accepts the record when m_valid & m_ready.
- m_data  out  REC_W  {edge, sat, coarse[COARSE_W-1:0], fine[FINE_W-1:0]}; edge 0 = rising, 1 = falling.
- overflow  out  1  sticky; set when a record is dropped because the FIFO is full.
- drop_cnt  out  8  saturating count of dropped records (stops at 255).

## Operation
- Reset values (async assert, sync release): t_q=0, c_q=0, coarse=0, primed=0, FIFO empty, m_valid=0, m_data=0, overflow=0, drop_cnt=0.
- Stage 1, every edge:
  - t_q <= taps; c_q <= coarse; coarse <= coarse+1 (wraps).
  - primed <= 1 one cycle after reset release.
  - t_p <= t_q (previous sample).
- Stage 2, event detection, only when en & primed:
  - rise = !t_p[0] & t_q[0]; fall = t_p[0] & !t_q[0]; masked by EDGE_MODE.
  - The first sample after reset never produces an event.
- Fine count = popcount(t_q) for rise, TAPS−popcount(t_q) for fall; bubbles inside the vector are therefore tolerated.
- sat = 1 when fine == TAPS (edge traversed the whole line in one cycle); the fine value is still recorded.
- Coarse in the record is the c_q that travelled with the same t_q sample.
- Stage 3: the registered record is written to the FIFO.
  - FIFO full and no pop this cycle: drop the record, set overflow, increment drop_cnt (saturating).
  - Simultaneous pop and write when full: write accepted, no drop.
- FIFO ordering: strict in-order. m_data is stable while m_valid & !m_ready.
- rise and fall cannot both be true in one cycle. Consecutive-cycle events are legal and each is recorded.
- overflow and drop_cnt clear only on reset.

## Timing
- taps captured at edge N gives a record written at edge N+2; m_valid is high after edge N+3 if the FIFO was empty (registered FIFO output).
- A pop at edge K presents the next entry immediately after edge K, with no bubble, when the FIFO holds ≥2 entries.
- Throughput: one record per cycle, sustained while m_ready=1.
- resetn asserted mid-operation: the pipeline and FIFO flush asynchronously, m_valid drops immediately, and in-flight events are lost (not counted as drops).
- Popcount may be pipelined internally only if total latency stays N+3 to m_valid.

## Test plan
All scenarios use TAPS=16, COARSE_W=8, DEPTH=4; release reset, then count the first clk edge as coarse 0.
- Rising event, EDGE_MODE=0: taps=0 on edges 0–4, taps=16'h003F from edge 5 -> one record edge=0, sat=0, coarse=5, fine=6; m_valid rises after edge 8; no further records while taps is constant.
- Falling event with bubble, EDGE_MODE=1: taps=16'hFFFF, then 16'hFD00 at coarse 20 -> edge=1, coarse=20, fine=9 (bubble ignored by popcount); the earlier rising transition yields no record.
- Saturation and both-edges mode, EDGE_MODE=2: taps 0 -> 16'hFFFF at coarse 10, back to 0 at coarse 11 -> records (0,1,10,16) then (1,1,11,16) on consecutive cycles.
- Overflow: m_ready=0, six rising events at coarse 3, 5, 7, 9, 11, 13 -> FIFO holds coarse 3, 5, 7, 9; overflow=1; drop_cnt=2. Then m_ready=1 -> four records drain in order and m_valid falls; overflow stays 1.
- Coarse wrap and enable: events at coarse 255 and the next cycle -> coarse fields 255 then 0. With en=0, a transition produces no record while coarse still advances.
- Reset mid-stream: two records queued, pulse resetn low for 1 cycle -> m_valid=0, overflow=0, drop_cnt=0, and coarse restarts at 0. Taps held at 16'h00FF across the reset -> no event from the first sample.

Source files
------------

// File: rtl/tdc_event_stamper_if.sv
// Record stream between the TDC event stamper and its consumer.
// Latency: none, wires only.
// Backpressure: the master holds data stable while valid is high and ready is low.
interface tdc_event_stamper_if #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tdc_event_stamper.sv
// Edge detector and time stamper for a carry-chain TDC: the fine count comes from the tap popcount, the coarse count from a free-running counter.
// Latency: taps captured at edge N are written to the FIFO at N+2; m.valid rises after N+3 when the FIFO was empty.
// Backpressure: the DEPTH-entry FIFO absorbs stalls; once it is full, new records are dropped and counted.
module tdc_event_stamper #(
    parameter  int TAPS      = 241,
    parameter  int COARSE_W  = 16,
    parameter  int DEPTH     = 16,
    parameter  int EDGE_MODE = 0,
    localparam int FINE_W    = $clog2(TAPS + 1),
    localparam int REC_W     = 2 + COARSE_W + FINE_W
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       en,
    input  logic [TAPS-1:0]            taps,
    tdc_event_stamper_if.master        m,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int   AW      = $clog2(DEPTH);
    localparam int   CW      = AW + 1;
    localparam logic RISE_EN = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam logic FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    // Stage 1: sample registers and the coarse counter.
    logic [TAPS-1:0]     t_q;
    logic                t_p0;      // only bit 0 of the previous sample is needed for edge detection
    logic [COARSE_W-1:0] coarse;
    logic [COARSE_W-1:0] c_q;
    logic                primed;    // t_q holds a real sample
    logic                hist_vld;  // t_p0 holds a real sample

    // Stage 2: detection result.
    logic [FINE_W-1:0]   ones;
    logic [FINE_W-1:0]   fine;
    logic                rise;
    logic                fall;
    logic                sat;
    logic                rec_vld;
    logic [REC_W-1:0]    rec_dat;

    // Stage 3: FIFO storage plus the registered head on the output.
    logic [REC_W-1:0]    mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       mem_cnt;
    logic                out_vld;
    logic [REC_W-1:0]    out_dat;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;
    logic                ld;

    // Capture the tap vector, tag it with the coarse count, and track sample validity after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_q      <= '0;
            t_p0     <= 1'b0;
            c_q      <= '0;
            coarse   <= '0;
            primed   <= 1'b0;
            hist_vld <= 1'b0;
        end else begin
            t_q      <= taps;
            t_p0     <= t_q[0];
            c_q      <= coarse;
            coarse   <= coarse + COARSE_W'(1);
            primed   <= 1'b1;
            hist_vld <= primed;
        end
    end

    // Popcount of the current sample; bubbles do not matter, only the number of set taps.
    always_comb begin
        ones = '0;
        for (int i = 0; i < TAPS; i++) begin
            ones = ones + FINE_W'(t_q[i]);
        end
    end

    // Edge detection on tap 0 and fine-count conversion; no event until two real samples exist.
    always_comb begin
        rise = 1'b0;
        fall = 1'b0;
        fine = ones;
        if (en && hist_vld) begin
            rise = RISE_EN && !t_p0 &&  t_q[0];
            fall = FALL_EN &&  t_p0 && !t_q[0];
        end
        if (fall) begin
            fine = FINE_W'(TAPS) - ones;
        end
        sat = (fine == FINE_W'(TAPS));
    end

    // Register the event record that travels with this sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rec_vld <= 1'b0;
            rec_dat <= '0;
        end else begin
            rec_vld <= rise || fall;
            rec_dat <= {fall, sat, c_q, fine};
        end
    end

    // FIFO occupancy includes the output register, so DEPTH records are held in total.
    always_comb begin
        pop   = out_vld && m.ready;
        full  = (mem_cnt + CW'(out_vld)) == CW'(DEPTH);
        wr_en = rec_vld && (!full || pop);
        drop  = rec_vld && full && !pop;
        ld    = (!out_vld || pop) && (mem_cnt != '0);
    end

    // Storage write; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rec_dat;
        end
    end

    // Pointer and count bookkeeping for the storage array.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            mem_cnt <= mem_cnt + CW'(wr_en) - CW'(ld);
        end
    end

    // Registered head: refill on pop or when empty so back-to-back pops show no bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (!out_vld || pop) begin
            out_vld <= (mem_cnt != '0);
            if (ld) begin
                out_dat <= mem[rd_ptr];
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign m.valid = out_vld;
    assign m.data  = out_dat;

endmodule

// File: tb/tb_tdc_event_stamper.sv
// Randomised and directed bench for tdc_event_stamper, run on three instances (rising, falling, both edges).
// A queue-based reference model predicts valid, data, overflow and drop count after every clock.
// The consumer ready is driven by the bench and is sometimes held low to force overflow.
module tb_tdc_event_stamper;

    localparam int TAPS  = 16;
    localparam int CWID  = 8;
    localparam int DEPTH = 4;
    localparam int RW    = 2 + CWID + 5;

    logic          clk    = 1'b0;
    logic          resetn = 1'b1;
    logic          en     = 1'b0;
    logic          rdy    = 1'b0;
    logic [15:0]   taps   = '0;

    logic          ovf  [3];
    logic [7:0]    drop [3];
    logic          vld  [3];
    logic [RW-1:0] dat  [3];

    tdc_event_stamper_if #(.DATA_W(RW)) if0 ();
    tdc_event_stamper_if #(.DATA_W(RW)) if1 ();
    tdc_event_stamper_if #(.DATA_W(RW)) if2 ();

    tdc_event_stamper #(.TAPS(TAPS), .COARSE_W(CWID), .DEPTH(DEPTH), .EDGE_MODE(0)) u_rise (
        .clk(clk), .resetn(resetn), .en(en), .taps(taps), .m(if0), .overflow(ovf[0]), .drop_cnt(drop[0]));
    tdc_event_stamper #(.TAPS(TAPS), .COARSE_W(CWID), .DEPTH(DEPTH), .EDGE_MODE(1)) u_fall (
        .clk(clk), .resetn(resetn), .en(en), .taps(taps), .m(if1), .overflow(ovf[1]), .drop_cnt(drop[1]));
    tdc_event_stamper #(.TAPS(TAPS), .COARSE_W(CWID), .DEPTH(DEPTH), .EDGE_MODE(2)) u_both (
        .clk(clk), .resetn(resetn), .en(en), .taps(taps), .m(if2), .overflow(ovf[2]), .drop_cnt(drop[2]));

    assign if0.ready = rdy;
    assign if1.ready = rdy;
    assign if2.ready = rdy;
    assign vld[0] = if0.valid;
    assign vld[1] = if1.valid;
    assign vld[2] = if2.valid;
    assign dat[0] = if0.data;
    assign dat[1] = if1.data;
    assign dat[2] = if2.data;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Records are held in one queue tagged with the instance mode and the edge at which they
    // entered the FIFO; a record is visible on the output from the edge after its write.
    typedef struct {
        int            mode;
        logic [RW-1:0] rec;
        int            wr;
    } ent_t;

    ent_t          mq[$];
    bit            pv   [3];
    logic [RW-1:0] prec [3];
    bit            eovf [3];
    int            edrop[3];
    int            ecnt;
    logic [15:0]   s1;
    logic [15:0]   s2;

    function automatic int front_idx(input int md);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].mode == md) return i;
        end
        return -1;
    endfunction

    function automatic int qsize(input int md);
        int n = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].mode == md) n++;
        end
        return n;
    endfunction

    function automatic bit visible(input int md);
        int idx = front_idx(md);
        return (idx >= 0) && (mq[idx].wr <= ecnt - 2);
    endfunction

    function automatic logic [RW-1:0] mk(input bit edg, input int fine, input int crs);
        logic [7:0] c8 = 8'(crs);
        logic [4:0] f5 = 5'(fine);
        return {edg, (fine == TAPS), c8, f5};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int md = 0; md < 3; md++) begin
            pv[md]    = 1'b0;
            prec[md]  = '0;
            eovf[md]  = 1'b0;
            edrop[md] = 0;
        end
        ecnt = 0;
        s1   = '0;
        s2   = '0;
    endtask

    task automatic model_edge();
        bit pop[3];
        int pre[3];
        for (int md = 0; md < 3; md++) begin
            pre[md] = qsize(md);
            pop[md] = visible(md) && rdy;
        end
        for (int md = 0; md < 3; md++) begin
            if (pop[md]) mq.delete(front_idx(md));
        end
        for (int md = 0; md < 3; md++) begin
            if (pv[md]) begin
                if (pre[md] == DEPTH && !pop[md]) begin
                    eovf[md] = 1'b1;
                    if (edrop[md] < 255) edrop[md]++;
                end else begin
                    mq.push_back('{md, prec[md], ecnt});
                end
            end
            pv[md] = 1'b0;
        end
        // s1 is the sample from the previous edge, s2 the one before it.
        if (ecnt >= 2 && en) begin
            int ones = $countones(s1);
            bit r = !s2[0] && s1[0];
            bit f = s2[0] && !s1[0];
            for (int md = 0; md < 3; md++) begin
                if (r && md != 1) begin
                    pv[md]   = 1'b1;
                    prec[md] = mk(1'b0, ones, ecnt - 1);
                end else if (f && md != 0) begin
                    pv[md]   = 1'b1;
                    prec[md] = mk(1'b1, TAPS - ones, ecnt - 1);
                end
            end
        end
        s2 = s1;
        s1 = taps;
        ecnt++;
    endtask

    task automatic check_all();
        for (int md = 0; md < 3; md++) begin
            bit v = visible(md);
            check_eq($sformatf("m%0d_valid", md), 32'(vld[md]), 32'(v));
            if (v) check_eq($sformatf("m%0d_data", md), 32'(dat[md]), 32'(mq[front_idx(md)].rec));
            check_eq($sformatf("m%0d_overflow", md), 32'(ovf[md]), 32'(eovf[md]));
            check_eq($sformatf("m%0d_drop_cnt", md), 32'(drop[md]), 32'(edrop[md]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [15:0] t, input logic e, input logic r);
        taps = t;
        en   = e;
        rdy  = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input logic [15:0] t);
        taps   = t;
        resetn = 1'b0;
        #1;
        for (int md = 0; md < 3; md++) begin
            check_eq($sformatf("rst_m%0d_valid", md), 32'(vld[md]), 32'd0);
            check_eq($sformatf("rst_m%0d_data", md), 32'(dat[md]), 32'd0);
            check_eq($sformatf("rst_m%0d_overflow", md), 32'(ovf[md]), 32'd0);
            check_eq($sformatf("rst_m%0d_drop_cnt", md), 32'(drop[md]), 32'd0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic [15:0] rand_taps();
        int k = $urandom_range(1, 15);
        logic [15:0] th = 16'((32'd1 << k) - 1);
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return th;
            3: return th ^ (16'd1 << $urandom_range(1, 15));
            4: return ~th;
            default: return 16'(~th) ^ (16'd1 << $urandom_range(1, 15));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] cur;
        logic        r;
        #2;

        // Rising event, fine 6 at coarse 5.
        do_reset(16'h0000);
        for (int e = 0; e < 12; e++) begin
            step((e >= 5) ? 16'h003F : 16'h0000, 1'b1, 1'b1);
            if (e == 8) begin
                check_eq("s1_valid", 32'(vld[0]), 32'd1);
                check_eq("s1_rec", 32'(dat[0]), 32'({1'b0, 1'b0, 8'd5, 5'd6}));
            end
        end

        // Falling event with a bubble.
        do_reset(16'h0000);
        for (int e = 0; e < 26; e++) begin
            step((e < 5) ? 16'h0000 : (e < 20) ? 16'hFFFF : 16'hFD00, 1'b1, 1'b1);
            if (e == 23) check_eq("s2_rec", 32'(dat[1]), 32'({1'b1, 1'b0, 8'd20, 5'd9}));
        end

        // Saturated edges on consecutive cycles, held in the FIFO.
        do_reset(16'h0000);
        for (int e = 0; e < 16; e++) begin
            step((e == 10) ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);
            if (e == 14) check_eq("s3_rec", 32'(dat[2]), 32'({1'b0, 1'b1, 8'd10, 5'd16}));
        end
        for (int e = 0; e < 6; e++) step(16'h0000, 1'b1, 1'b1);

        // Overflow with the consumer stalled, then drain.
        do_reset(16'h0000);
        for (int e = 0; e < 18; e++) begin
            step((e % 2 == 1 && e >= 3 && e <= 13) ? 16'h000F : 16'h0000, 1'b1, 1'b0);
            if (e == 16) begin
                check_eq("s4_overflow", 32'(ovf[0]), 32'd1);
                check_eq("s4_drop_cnt", 32'(drop[0]), 32'd2);
            end
        end
        for (int e = 0; e < 8; e++) step(16'h0000, 1'b1, 1'b1);
        check_eq("s4_drained", 32'(vld[0]), 32'd0);

        // Coarse wrap, then transitions with detection disabled.
        do_reset(16'h0000);
        for (int e = 0; e < 266; e++) begin
            step((e == 255) ? 16'hFFFF : 16'h0000, 1'b1, 1'b1);
            if (e == 258) check_eq("s5_rec255", 32'(dat[2]), 32'({1'b0, 1'b1, 8'd255, 5'd16}));
            if (e == 259) check_eq("s5_rec0", 32'(dat[2]), 32'({1'b1, 1'b1, 8'd0, 5'd16}));
        end
        for (int e = 0; e < 12; e++) step(((e / 2) % 2 == 1) ? 16'h0FFF : 16'h0000, 1'b0, 1'b1);
        for (int e = 0; e < 6; e++) step(16'h0000, 1'b1, 1'b1);

        // Reset with records queued; taps held high across reset.
        do_reset(16'h0000);
        for (int e = 0; e < 10; e++) step((e == 3 || e >= 5) ? 16'h00FF : 16'h0000, 1'b1, 1'b0);
        do_reset(16'h00FF);
        for (int e = 0; e < 12; e++) step((e < 6) ? 16'h00FF : 16'h0000, 1'b1, 1'b1);

        // Random traffic with random stalls and enable.
        do_reset(16'h0000);
        cur = 16'h0000;
        r   = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) cur = rand_taps();
            if ($urandom_range(0, 7) == 0) r = ~r;
            step(cur, ($urandom_range(0, 15) != 0), r);
        end

        // Long stall with an event every cycle to saturate the drop counter.
        for (int i = 0; i < 600; i++) step((i % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(16'h0000, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
